// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bundle of the shared data-memory port.
// master drives the request; slave is the arbiter's view.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW = 7
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [2:0]    amp;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;

  modport master (
    output req, we, addr, amp, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, amp, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port.
// Accesses are serialised through an idle/issue/response FSM with a one-cycle ack.
module dmem_port_arbiter #(
  parameter int unsigned AW       = 7,
  parameter int unsigned RD_LAT   = 1,
  parameter bit          CPU_PRIO = 1'b0
) (
  input  logic                      clk,
  input  logic                      rstn,
  dmem_port_arbiter_if.slave        m0,
  dmem_port_arbiter_if.slave        m1,
  output logic                      m0_stall,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [2:0]                mem_amp,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic                      gnt_id
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e        state;
  logic          last_gnt;
  logic [CntW-1:0] cnt;
  logic          ack0, ack1;
  logic [31:0]   rdata0, rdata1;

  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [2:0]    sel_amp;
  logic [31:0]   sel_wdata;

  // Under contention, round-robin favours whoever was not served last.
  always_comb begin
    pick = 1'b0;
    if (m0.req && m1.req) begin
      pick = CPU_PRIO ? 1'b0 : ~last_gnt;
    end else if (m1.req) begin
      pick = 1'b1;
    end
    sel_we    = pick ? m1.we    : m0.we;
    sel_addr  = pick ? m1.addr  : m0.addr;
    sel_amp   = pick ? m1.amp   : m0.amp;
    sel_wdata = pick ? m1.wdata : m0.wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= StIdle;
      last_gnt  <= 1'b1;
      gnt_id    <= 1'b0;
      cnt       <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_amp   <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (m0.req || m1.req) begin
            gnt_id    <= pick;
            last_gnt  <= pick;
            mem_we    <= sel_we;
            mem_re    <= ~sel_we;
            mem_addr  <= sel_addr;
            mem_amp   <= sel_amp;
            mem_wdata <= sel_wdata;
            cnt       <= CntW'(RD_LAT - 1);
            state     <= StIssue;
          end
        end
        StIssue: begin
          // Writes last one cycle; reads hold mem_re for RD_LAT cycles.
          if (mem_we || cnt == '0) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            state  <= StResp;
            if (gnt_id) ack1 <= 1'b1;
            else        ack0 <= 1'b1;
            if (mem_re) begin
              if (gnt_id) rdata1 <= mem_rdata;
              else        rdata0 <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StResp: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign m0.rdata = rdata0;
  assign m0.ack   = ack0;
  assign m1.rdata = rdata1;
  assign m1.ack   = ack1;
  assign m0_stall = m0.req & ~ack0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: round-robin, CPU-priority and RD_LAT=3 instances.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance a: round-robin, RD_LAT=1
  dmem_port_arbiter_if #(.AW(7)) a0 ();
  dmem_port_arbiter_if #(.AW(7)) a1 ();
  logic a_stall, a_re, a_we, a_gnt;
  logic [6:0] a_addr;
  logic [2:0] a_amp;
  logic [31:0] a_wdata, a_rdata;

  dmem_port_arbiter #(.AW(7), .RD_LAT(1), .CPU_PRIO(1'b0)) u_rr (
    .clk(clk), .rstn(rstn), .m0(a0), .m1(a1), .m0_stall(a_stall),
    .mem_re(a_re), .mem_we(a_we), .mem_addr(a_addr), .mem_amp(a_amp),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .gnt_id(a_gnt)
  );

  // Instance b: CPU priority, RD_LAT=1
  dmem_port_arbiter_if #(.AW(7)) b0 ();
  dmem_port_arbiter_if #(.AW(7)) b1 ();
  logic b_stall, b_re, b_we, b_gnt;
  logic [6:0] b_addr;
  logic [2:0] b_amp;
  logic [31:0] b_wdata, b_rdata;

  dmem_port_arbiter #(.AW(7), .RD_LAT(1), .CPU_PRIO(1'b1)) u_prio (
    .clk(clk), .rstn(rstn), .m0(b0), .m1(b1), .m0_stall(b_stall),
    .mem_re(b_re), .mem_we(b_we), .mem_addr(b_addr), .mem_amp(b_amp),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .gnt_id(b_gnt)
  );

  // Instance c: round-robin, RD_LAT=3
  dmem_port_arbiter_if #(.AW(7)) c0 ();
  dmem_port_arbiter_if #(.AW(7)) c1 ();
  logic c_stall, c_re, c_we, c_gnt;
  logic [6:0] c_addr;
  logic [2:0] c_amp;
  logic [31:0] c_wdata, c_rdata;

  dmem_port_arbiter #(.AW(7), .RD_LAT(3), .CPU_PRIO(1'b0)) u_lat3 (
    .clk(clk), .rstn(rstn), .m0(c0), .m1(c1), .m0_stall(c_stall),
    .mem_re(c_re), .mem_we(c_we), .mem_addr(c_addr), .mem_amp(c_amp),
    .mem_wdata(c_wdata), .mem_rdata(c_rdata), .gnt_id(c_gnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_r0, exp_r1;

  initial begin
    a0.req = 0; a0.we = 0; a0.addr = 0; a0.amp = 0; a0.wdata = 0;
    a1.req = 0; a1.we = 0; a1.addr = 0; a1.amp = 0; a1.wdata = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.amp = 0; b0.wdata = 0;
    b1.req = 0; b1.we = 0; b1.addr = 0; b1.amp = 0; b1.wdata = 0;
    c0.req = 0; c0.we = 0; c0.addr = 0; c0.amp = 0; c0.wdata = 0;
    c1.req = 0; c1.we = 0; c1.addr = 0; c1.amp = 0; c1.wdata = 0;
    a_rdata = 0; b_rdata = 0; c_rdata = 0;

    tick();
    chk("rst_re", a_re, 0);
    chk("rst_we", a_we, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_ack0", a0.ack, 0);
    chk("rst_rdata0", a0.rdata, 0);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_stall", a_stall, 0);
    tick();
    rstn = 1;
    tick();

    // m0 write addr 5
    a0.we = 1; a0.addr = 5; a0.amp = 3'b010; a0.wdata = 32'hDEADBEEF; a0.req = 1;
    #1;
    chk("wr_stall_t0", a_stall, 1);
    chk("wr_we_t0", a_we, 0);
    tick();
    chk("wr_we_t1", a_we, 1);
    chk("wr_re_t1", a_re, 0);
    chk("wr_addr_t1", a_addr, 5);
    chk("wr_amp_t1", a_amp, 3'b010);
    chk("wr_wdata_t1", a_wdata, 32'hDEADBEEF);
    chk("wr_gnt_t1", a_gnt, 0);
    chk("wr_ack_t1", a0.ack, 0);
    chk("wr_stall_t1", a_stall, 1);
    a0.addr = 9; a0.wdata = 0; a0.amp = 0;
    tick();
    chk("wr_ack_t2", a0.ack, 1);
    chk("wr_we_t2", a_we, 0);
    chk("wr_stall_t2", a_stall, 0);
    a0.req = 0;
    tick();
    chk("wr_ack_t3", a0.ack, 0);

    // m0 read addr 5
    a0.we = 0; a0.addr = 5; a0.req = 1; a_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_re_t1", a_re, 1);
    chk("rd_we_t1", a_we, 0);
    chk("rd_addr_t1", a_addr, 5);
    chk("rd_rdata_t1", a0.rdata, 0);
    tick();
    chk("rd_ack_t2", a0.ack, 1);
    chk("rd_rdata_t2", a0.rdata, 32'hDEADBEEF);
    chk("rd_re_t2", a_re, 0);
    a0.req = 0; a_rdata = 32'h12345678;
    tick();
    chk("rd_ack_t3", a0.ack, 0);
    chk("rd_hold_t3", a0.rdata, 32'hDEADBEEF);

    // Reset clears rdata and round-robin history
    rstn = 0;
    #1;
    chk("rst2_rdata0", a0.rdata, 0);
    tick();
    rstn = 1;

    // Round-robin contention from reset: m0, m1, m0
    exp_r0 = 0; exp_r1 = 0;
    a0.we = 0; a0.addr = 1; a0.req = 1;
    a1.we = 0; a1.addr = 2; a1.req = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_gnt", a_gnt, k % 2);
      chk("rr_addr", a_addr, (k % 2 == 1) ? 2 : 1);
      chk("rr_issue_ack", {a0.ack, a1.ack}, 0);
      a_rdata = 32'hA000_0000 + k;
      tick();
      if (k % 2 == 1) exp_r1 = 32'hA000_0000 + k;
      else            exp_r0 = 32'hA000_0000 + k;
      chk("rr_ack0", a0.ack, (k % 2 == 0));
      chk("rr_ack1", a1.ack, (k % 2 == 1));
      chk("rr_rdata0", a0.rdata, exp_r0);
      chk("rr_rdata1", a1.rdata, exp_r1);
      if (k == 2) begin
        a0.req = 0; a1.req = 0;
      end
      tick();
      chk("rr_idle_ack", {a0.ack, a1.ack}, 0);
    end

    // Reset asserted during a write's issue cycle
    a0.we = 1; a0.addr = 3; a0.wdata = 32'hCAFE0001; a0.req = 1;
    tick();
    chk("rmid_we_pre", a_we, 1);
    #2;
    rstn = 0;
    #1;
    chk("rmid_we_drop", a_we, 0);
    chk("rmid_ack", a0.ack, 0);
    tick();
    chk("rmid_ack_edge", a0.ack, 0);
    chk("rmid_we_edge", a_we, 0);
    rstn = 1;
    tick();
    chk("rmid_restart_we", a_we, 1);
    chk("rmid_restart_addr", a_addr, 3);
    tick();
    chk("rmid_restart_ack", a0.ack, 1);
    a0.req = 0;
    tick();

    // CPU priority: m0 wins while both held
    b0.we = 0; b0.addr = 4; b0.req = 1;
    b1.we = 0; b1.addr = 6; b1.req = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("prio_gnt", b_gnt, 0);
      tick();
      chk("prio_ack0", b0.ack, 1);
      chk("prio_ack1", b1.ack, 0);
      if (k == 2) b0.req = 0;
      tick();
    end
    tick();
    chk("prio_gnt_m1", b_gnt, 1);
    chk("prio_addr_m1", b_addr, 6);
    tick();
    chk("prio_ack1_late", b1.ack, 1);
    b1.req = 0;
    tick();

    // RD_LAT=3 read by m1
    c1.we = 0; c1.addr = 7; c1.req = 1; c_rdata = 32'h0000_0001;
    tick();
    chk("lat3_re1", c_re, 1);
    chk("lat3_gnt", c_gnt, 1);
    chk("lat3_addr", c_addr, 7);
    c_rdata = 32'h0000_0111;
    tick();
    chk("lat3_re2", c_re, 1);
    chk("lat3_ack2", c1.ack, 0);
    c_rdata = 32'h0000_0222;
    tick();
    chk("lat3_re3", c_re, 1);
    chk("lat3_ack3", c1.ack, 0);
    c_rdata = 32'h0000_0333;
    tick();
    chk("lat3_ack4", c1.ack, 1);
    chk("lat3_rdata", c1.rdata, 32'h0000_0333);
    chk("lat3_re4", c_re, 0);
    chk("lat3_ack0", c0.ack, 0);
    c1.req = 0; c_rdata = 32'h0000_0444;
    tick();
    chk("lat3_ack5", c1.ack, 0);
    chk("lat3_hold", c1.rdata, 32'h0000_0333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
